// File: rtl/led_pwm_pkg.sv
// ============================================================================
// Module : led_pwm_pkg
// Brief  : Register map, CTRL bit positions, field widths and reset values
//          shared by the LED PWM dimmer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pwm_pkg;

    localparam int C_DATA_W     = 32;
    localparam int C_ADDR_W     = 2;
    localparam int C_PRESCALE_W = 16;
    localparam int C_BLINK_W    = 16;
    localparam int C_CTRL_W     = 3;

    localparam logic [C_ADDR_W-1:0] C_ADDR_CTRL     = 2'd0;
    localparam logic [C_ADDR_W-1:0] C_ADDR_DUTY     = 2'd1;
    localparam logic [C_ADDR_W-1:0] C_ADDR_PRESCALE = 2'd2;
    localparam logic [C_ADDR_W-1:0] C_ADDR_BLINK    = 2'd3;

    localparam int C_CTRL_ENABLE   = 0;
    localparam int C_CTRL_BLINK_EN = 1;
    localparam int C_CTRL_INVERT   = 2;

    typedef struct packed {
        logic invert;
        logic blink_en;
        logic enable;
    } ctrl_t;

    localparam ctrl_t                   C_CTRL_RST     = 3'b000;
    localparam logic [C_DATA_W-1:0]     C_DUTY_RST     = '0;
    localparam logic [C_PRESCALE_W-1:0] C_PRESCALE_RST = '0;
    localparam logic [C_BLINK_W-1:0]    C_BLINK_RST    = '0;

endpackage

`default_nettype wire

// File: rtl/led_pwm_dimmer_if.sv
// ============================================================================
// Module : led_pwm_dimmer_if
// Brief  : Avalon-MM slave register bus of the LED PWM dimmer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pwm_dimmer_if;
    import led_pwm_pkg::*;

    logic [C_ADDR_W-1:0] address;
    logic                chipselect;
    logic                write_n;
    logic [C_DATA_W-1:0] writedata;
    logic [C_DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

`default_nettype wire

// File: rtl/led_pwm_timebase.sv
// ============================================================================
// Module : led_pwm_timebase
// Brief  : Prescaler tick generator and PWM period counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    enable,
    input  wire logic [C_PRESCALE_W-1:0] prescale,
    input  wire logic                    prescale_wr,
    output logic      [PWM_W-1:0]        pwm_cnt,
    output logic                         period_end
);

    logic [C_PRESCALE_W-1:0] r_pre_cnt;
    logic [PWM_W-1:0]        r_pwm_cnt;
    logic                    w_tick;

    assign w_tick     = enable && (r_pre_cnt == prescale);
    assign period_end = w_tick && (r_pwm_cnt == {PWM_W{1'b1}});
    assign pwm_cnt    = r_pwm_cnt;

    // A PRESCALE write restarts the tick interval so the new rate applies at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (!enable || prescale_wr || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + C_PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else if (!enable) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pwm_dimmer.sv
// ============================================================================
// Module : led_pwm_dimmer
// Brief  : Avalon-MM controlled PWM dimmer / blinker for an LED pattern.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_dimmer
    import led_pwm_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int PWM_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    led_pwm_dimmer_if.slave        bus,
    input  wire logic [N_LEDS-1:0] pattern_in,
    output logic      [N_LEDS-1:0] led_out
);

    ctrl_t                   r_ctrl;
    logic [PWM_W:0]          r_duty_req;
    logic [PWM_W:0]          r_duty_act;
    logic [C_PRESCALE_W-1:0] r_prescale;
    logic [C_BLINK_W-1:0]    r_blink;
    logic [C_BLINK_W-1:0]    r_blink_cnt;
    logic                    r_phase;
    logic [N_LEDS-1:0]       r_led_out;

    logic                    w_we;
    logic                    w_prescale_wr;
    logic [PWM_W-1:0]        w_pwm_cnt;
    logic                    w_period_end;
    logic                    w_pwm_on;
    logic                    w_gate;
    logic [C_DATA_W-1:0]     w_readdata;
    logic                    w_unused_wdata;

    assign w_we           = bus.chipselect && !bus.write_n;
    assign w_prescale_wr  = w_we && (bus.address == C_ADDR_PRESCALE);
    assign w_unused_wdata = ^bus.writedata[C_DATA_W-1:C_PRESCALE_W];

    led_pwm_timebase #(
        .PWM_W (PWM_W)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .enable      (r_ctrl.enable),
        .prescale    (r_prescale),
        .prescale_wr (w_prescale_wr),
        .pwm_cnt     (w_pwm_cnt),
        .period_end  (w_period_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl     <= C_CTRL_RST;
            r_duty_req <= C_DUTY_RST[PWM_W:0];
            r_prescale <= C_PRESCALE_RST;
            r_blink    <= C_BLINK_RST;
        end else if (w_we) begin
            case (bus.address)
                C_ADDR_CTRL: begin
                    r_ctrl.enable   <= bus.writedata[C_CTRL_ENABLE];
                    r_ctrl.blink_en <= bus.writedata[C_CTRL_BLINK_EN];
                    r_ctrl.invert   <= bus.writedata[C_CTRL_INVERT];
                end
                C_ADDR_DUTY:     r_duty_req <= bus.writedata[PWM_W:0];
                C_ADDR_PRESCALE: r_prescale <= bus.writedata[C_PRESCALE_W-1:0];
                default:         r_blink    <= bus.writedata[C_BLINK_W-1:0];
            endcase
        end
    end

    always_comb begin
        w_readdata = '0;
        case (bus.address)
            C_ADDR_CTRL: begin
                w_readdata[C_CTRL_ENABLE]   = r_ctrl.enable;
                w_readdata[C_CTRL_BLINK_EN] = r_ctrl.blink_en;
                w_readdata[C_CTRL_INVERT]   = r_ctrl.invert;
            end
            C_ADDR_DUTY:     w_readdata[PWM_W:0]          = r_duty_req;
            C_ADDR_PRESCALE: w_readdata[C_PRESCALE_W-1:0] = r_prescale;
            default:         w_readdata[C_BLINK_W-1:0]    = r_blink;
        endcase
    end

    assign bus.readdata = w_readdata;

    // Duty only changes at a period boundary so no period is ever truncated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty_act <= '0;
        end else if (w_period_end) begin
            r_duty_act <= r_duty_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!r_ctrl.enable || !r_ctrl.blink_en) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_period_end) begin
            if (r_blink_cnt == r_blink) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + C_BLINK_W'(1);
            end
        end
    end

    assign w_pwm_on = ({1'b0, w_pwm_cnt} < r_duty_act);
    assign w_gate   = r_ctrl.enable && w_pwm_on && r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_out <= '0;
        end else begin
            r_led_out <= (pattern_in & {N_LEDS{w_gate}}) ^ {N_LEDS{r_ctrl.invert}};
        end
    end

    assign led_out = r_led_out;

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_dimmer.sv
// ============================================================================
// Module : tb_led_pwm_dimmer
// Brief  : Self-checking bench for led_pwm_dimmer against a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pwm_dimmer;
    import led_pwm_pkg::*;

    localparam int N_LEDS = 8;
    localparam int PWM_W  = 8;
    localparam int PER    = 1 << PWM_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_LEDS-1:0] pattern_in;
    logic [N_LEDS-1:0] led_out;

    led_pwm_dimmer_if bus ();

    led_pwm_dimmer #(
        .N_LEDS (N_LEDS),
        .PWM_W  (PWM_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pattern_in (pattern_in),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int on_cnt  = 0;

    // Model: time is counted in clocks since the prescaler restarted and ticks
    // since enable; the PWM position is simply ticks modulo the period length.
    logic [2:0]  m_ctrl;
    logic [8:0]  m_duty;
    logic [15:0] m_pre;
    logic [15:0] m_blk;
    int          m_clk;
    int          m_ticks;
    int          m_act;
    int          m_per;
    logic        m_phase;
    logic        m_pe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_duty = '0; m_pre = '0; m_blk = '0;
        m_clk = 0; m_ticks = 0; m_act = 0; m_per = 0;
        m_phase = 1'b1; m_pe = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return {23'd0, m_duty};
            2'd2:    return {16'd0, m_pre};
            default: return {16'd0, m_blk};
        endcase
    endfunction

    // One clock: predict the registered LED value, advance the model, then sample
    task automatic step();
        logic       en, bl, inv, tick, pe, on, we;
        int         pwm;
        logic [7:0] exp_led;
        en  = m_ctrl[0];
        bl  = m_ctrl[1];
        inv = m_ctrl[2];
        tick = en && ((m_clk % (int'(m_pre) + 1)) == int'(m_pre));
        pwm  = m_ticks % PER;
        on   = pwm < m_act;
        exp_led = (pattern_in & {8{en & on & m_phase}}) ^ {8{inv}};
        pe   = tick && (pwm == PER - 1);
        we   = bus.chipselect && !bus.write_n;
        if (en) begin
            m_clk = (we && bus.address == 2'd2) ? 0 : m_clk + 1;
            if (tick) m_ticks++;
        end else begin
            m_clk = 0;
            m_ticks = 0;
        end
        if (pe) m_act = int'(m_duty);
        if (!en || !bl) begin
            m_per = 0;
            m_phase = 1'b1;
        end else if (pe) begin
            if (m_per == int'(m_blk)) begin
                m_per = 0;
                m_phase = !m_phase;
            end else begin
                m_per++;
            end
        end
        if (we) begin
            case (bus.address)
                2'd0:    m_ctrl = bus.writedata[2:0];
                2'd1:    m_duty = bus.writedata[8:0];
                2'd2:    m_pre  = bus.writedata[15:0];
                default: m_blk  = bus.writedata[15:0];
            endcase
        end
        m_pe = pe;
        @(posedge clk);
        #1;
        check("led_out", {24'd0, led_out}, {24'd0, exp_led});
        check("readdata", bus.readdata, exp_rd(bus.address));
        if (led_out != '0) on_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic sync_period();
        int k = 0;
        do begin
            step();
            k++;
        end while (!m_pe && k < 5000);
        check("sync_period", {31'd0, m_pe}, 32'd1);
    endtask

    task automatic run_len(input logic want_on, output int len);
        len = 0;
        while (((led_out != '0) == want_on) && len < 3000) begin
            step();
            len++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len_on, len_off, dummy;
        reset = 1'b1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        pattern_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_led", {24'd0, led_out}, 32'd0);
        check("reset_rd", bus.readdata, 32'd0);
        reset = 1'b0;
        run(3);

        // Basic duty: 64 of every 256 clocks
        pattern_in = 8'hA5;
        bus_write(2'd2, 32'd0);
        bus_write(2'd1, 32'd64);
        bus_write(2'd0, 32'd1);
        sync_period();
        on_cnt = 0; run(PER);
        check("duty64_on", on_cnt, 64);

        // Shadowing of DUTY within a period
        sync_period();
        on_cnt = 0; run(100); bus_write(2'd1, 32'd200); run(155);
        check("shadow_cur", on_cnt, 64);
        on_cnt = 0; run(PER);
        check("shadow_next", on_cnt, 200);
        run(50); bus_write(2'd1, 32'd64); run(205);
        dummy = 0;
        while ((m_ticks % PER) != PER - 1 && dummy < 2000) begin
            step();
            dummy++;
        end
        bus_write(2'd1, 32'd200);
        check("pe_write_aligned", {31'd0, m_pe}, 32'd1);
        on_cnt = 0; run(PER);
        check("pe_write_cur", on_cnt, 64);
        on_cnt = 0; run(PER);
        check("pe_write_next", on_cnt, 200);

        // Extremes
        bus_write(2'd1, 32'd0);
        sync_period();
        on_cnt = 0; run(PER);
        check("duty0_on", on_cnt, 0);
        bus_write(2'd1, 32'd256);
        sync_period();
        pattern_in = 8'h0F; step();
        check("full_0f", {24'd0, led_out}, 32'h0F);
        pattern_in = 8'hF0; step();
        check("full_f0", {24'd0, led_out}, 32'hF0);
        on_cnt = 0; run(PER);
        check("full_on", on_cnt, PER);

        // Blink every 2 periods
        pattern_in = 8'hA5;
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'd3);
        sync_period();
        on_cnt = 0; run(4 * PER);
        check("blink_on", on_cnt, 2 * PER);
        bus_write(2'd0, 32'd1);
        on_cnt = 0; run(PER);
        check("blink_off_steady", on_cnt, PER);

        // Invert / disable / slow prescale
        bus_write(2'd0, 32'd4);
        run(2);
        check("invert_dis", {24'd0, led_out}, 32'hFF);
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'd5);
        sync_period();
        run(3);
        check("invert_duty0", {24'd0, led_out}, 32'hFF);
        bus_write(2'd0, 32'd0);
        bus_write(2'd2, 32'd3);
        bus_write(2'd1, 32'd64);
        bus_write(2'd0, 32'd1);
        run_len(1'b0, dummy);
        run_len(1'b1, len_on);
        run_len(1'b0, len_off);
        check("pre3_on_len", len_on, 256);
        check("pre3_off_len", len_off, 768);

        // Randomised register traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus_write(2'd0, $urandom_range(0, 7) | ($urandom & 32'hFFFF_FFF8));
                    1: bus_write(2'd1, $urandom_range(0, 300) | ($urandom & 32'hFFFF_FE00));
                    2: bus_write(2'd2, $urandom_range(0, 3) | ($urandom & 32'hFFFF_0000));
                    default: bus_write(2'd3, $urandom_range(0, 3) | ($urandom & 32'hFFFF_0000));
                endcase
            end else begin
                bus.address = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) pattern_in = 8'($urandom);
                step();
            end
        end

        // Asynchronous reset mid-run
        bus_write(2'd2, 32'd5);
        bus_write(2'd3, 32'd7);
        bus_write(2'd1, 32'd33);
        bus_write(2'd0, 32'd4);
        run(2);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_led", {24'd0, led_out}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus.address = 2'(a);
            #1;
            check("async_rst_rd", bus.readdata, 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_write(2'd0, 32'd1);
        check("post_rst_write", bus.readdata, 32'd1);
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
